// File: rtl/retire_trace_pkg.sv
// Shared defaults and ROB-side types for the retirement trace buffer.
package common;
    localparam int unsigned RETIRE_TRACE_DEPTH  = 16;
    localparam int unsigned RETIRE_HANG_TIMEOUT = 40;
endpackage

package rob_defs;
    typedef logic [5:0]  t_rob_id;
    typedef logic [15:0] t_simid;

    typedef struct packed {
        t_rob_id     robid;
        t_simid      simid;
        logic        dst_vld;
        logic [4:0]  dst_reg;
        logic [31:0] dst_data;
        logic        ebreak;
        logic [31:0] stamp;
    } t_retire_trace_pkt;

    typedef enum logic [1:0] {
        RT_RUN   = 2'd0,
        RT_DRAIN = 2'd1,
        RT_DONE  = 2'd2
    } t_retire_trace_state;
endpackage

// File: rtl/retire_trace_fifo.sv
// Trace packet FIFO: RAM array with a registered head word, so a written
// packet first appears on o_data the cycle after its write.
module retire_trace_fifo
    import rob_defs::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_wr_en,
    input  t_retire_trace_pkt       i_wr_data,
    input  logic                    i_rd_en,
    output logic                    o_valid,
    output logic                    o_full,
    output logic [$clog2(DEPTH):0]  o_count,
    output t_retire_trace_pkt       o_data
);
    localparam int AW = $clog2(DEPTH);

    t_retire_trace_pkt r_mem [DEPTH];
    t_retire_trace_pkt r_head;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [AW-1:0]     w_rd_ptr_next;
    logic              w_wr;
    logic              w_rd;

    assign w_rd          = i_rd_en && (r_count != '0);
    assign o_full        = (r_count == (AW+1)'(DEPTH));
    // A full buffer still takes a write when the head leaves in the same cycle.
    assign w_wr          = i_wr_en && (!o_full || w_rd);
    assign w_rd_ptr_next = r_rd_ptr + AW'(w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
            // Forward the incoming word when it lands in the slot that becomes head.
            if (w_wr && (r_wr_ptr == w_rd_ptr_next)) begin
                r_head <= i_wr_data;
            end else begin
                r_head <= r_mem[w_rd_ptr_next];
            end
        end
    end

    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign o_data  = o_valid ? r_head : '0;
endmodule

// File: rtl/retire_trace.sv
// Retirement trace capture: stamps retiring uops into a FIFO, counts retires and
// drops, watches for hangs and drains the buffer after EBREAK or a hang.
module retire_trace
    import rob_defs::*;
    import common::*;
#(
    parameter int unsigned DEPTH        = RETIRE_TRACE_DEPTH,
    parameter int unsigned HANG_TIMEOUT = RETIRE_HANG_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              retire_valid_rb1,
    input  t_rob_id           retire_robid_rb1,
    input  t_simid            retire_simid_rb1,
    input  logic              retire_dst_vld_rb1,
    input  logic [4:0]        retire_dst_reg_rb1,
    input  logic [31:0]       retire_dst_data_rb1,
    input  logic              retire_ebreak_rb1,
    input  logic              trace_ready,
    output logic              trace_valid,
    output t_retire_trace_pkt trace_pkt,
    output logic              hang_detected,
    output logic              done,
    output logic [31:0]       retire_count,
    output logic [15:0]       drop_count
);
    localparam int             WDW      = $clog2(HANG_TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(HANG_TIMEOUT);

    t_retire_trace_state    r_state;
    t_retire_trace_state    w_state_next;
    logic [31:0]            r_cycle;
    logic [31:0]            r_retire_count;
    logic [15:0]            r_drop_count;
    logic [WDW-1:0]         r_wdog;
    logic [WDW-1:0]         w_wdog_inc;
    logic                   r_hang;
    logic                   w_hang_fire;
    logic                   w_enq_req;
    logic                   w_deq;
    logic                   w_full;
    logic                   w_drop;
    logic [$clog2(DEPTH):0] w_occupancy;
    t_retire_trace_pkt      w_enq_pkt;

    assign w_enq_req = (r_state == RT_RUN) && retire_valid_rb1;
    assign w_deq     = trace_valid && trace_ready;
    assign w_drop    = w_enq_req && w_full && !w_deq;

    assign w_enq_pkt = '{robid:    retire_robid_rb1,
                         simid:    retire_simid_rb1,
                         dst_vld:  retire_dst_vld_rb1,
                         dst_reg:  retire_dst_reg_rb1,
                         dst_data: retire_dst_data_rb1,
                         ebreak:   retire_ebreak_rb1,
                         stamp:    r_cycle};

    retire_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_enq_req),
        .i_wr_data (w_enq_pkt),
        .i_rd_en   (trace_ready),
        .o_valid   (trace_valid),
        .o_full    (w_full),
        .o_count   (w_occupancy),
        .o_data    (trace_pkt)
    );

    // Watchdog holds the idle cycles elapsed since the last retire; the retire
    // cycle itself is elapsed-0, so a retire reloads it with 1.
    assign w_wdog_inc  = (r_wdog == WD_LIMIT) ? r_wdog : r_wdog + 1'b1;
    assign w_hang_fire = !retire_valid_rb1 && (w_wdog_inc == WD_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle        <= '0;
            r_retire_count <= '0;
            r_drop_count   <= '0;
            r_wdog         <= '0;
            r_hang         <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (retire_valid_rb1) begin
                r_retire_count <= r_retire_count + 32'd1;
                r_wdog         <= WDW'(1);
            end else begin
                r_wdog <= w_wdog_inc;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
            if (w_hang_fire) begin
                r_hang <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RT_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RT_RUN: begin
                if ((retire_valid_rb1 && retire_ebreak_rb1) || w_hang_fire) begin
                    w_state_next = RT_DRAIN;
                end
            end
            RT_DRAIN: begin
                if (w_occupancy == '0) begin
                    w_state_next = RT_DONE;
                end
            end
            RT_DONE:  w_state_next = RT_DONE;
            default:  w_state_next = RT_RUN;
        endcase
    end

    assign hang_detected = r_hang;
    assign done          = (r_state == RT_DONE);
    assign retire_count  = r_retire_count;
    assign drop_count    = r_drop_count;
endmodule

// File: tb/tb_retire_trace.sv
// Bench for retire_trace: table vectors, hand-built corner sequences and
// randomized traffic against a queue-based reference model.
module tb_retire_trace;
    import rob_defs::*;

    localparam int DEPTH = 16;
    localparam int HT    = 40;

    logic              clk = 1'b0;
    logic              reset;
    logic              retire_valid_rb1;
    t_rob_id           retire_robid_rb1;
    t_simid            retire_simid_rb1;
    logic              retire_dst_vld_rb1;
    logic [4:0]        retire_dst_reg_rb1;
    logic [31:0]       retire_dst_data_rb1;
    logic              retire_ebreak_rb1;
    logic              trace_ready;
    logic              trace_valid;
    t_retire_trace_pkt trace_pkt;
    logic              hang_detected;
    logic              done;
    logic [31:0]       retire_count;
    logic [15:0]       drop_count;

    always #5 clk = ~clk;

    retire_trace #(.DEPTH(DEPTH), .HANG_TIMEOUT(HT)) dut (
        .clk                 (clk),
        .reset               (reset),
        .retire_valid_rb1    (retire_valid_rb1),
        .retire_robid_rb1    (retire_robid_rb1),
        .retire_simid_rb1    (retire_simid_rb1),
        .retire_dst_vld_rb1  (retire_dst_vld_rb1),
        .retire_dst_reg_rb1  (retire_dst_reg_rb1),
        .retire_dst_data_rb1 (retire_dst_data_rb1),
        .retire_ebreak_rb1   (retire_ebreak_rb1),
        .trace_ready         (trace_ready),
        .trace_valid         (trace_valid),
        .trace_pkt           (trace_pkt),
        .hang_detected       (hang_detected),
        .done                (done),
        .retire_count        (retire_count),
        .drop_count          (drop_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state: queue of packets plus plain counters.
    t_retire_trace_pkt mq[$];
    int                m_st;
    int                m_last;
    logic              m_hang;
    logic [31:0]       m_rc;
    logic [15:0]       m_dc;

    typedef struct {
        logic        rv;
        logic [5:0]  rob;
        logic        ev;
        logic [5:0]  erob;
        logic [31:0] estamp;
        logic [31:0] erc;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic t_retire_trace_pkt mk(input logic [5:0] rob, input logic eb, input logic [31:0] st);
        t_retire_trace_pkt p;
        p.robid    = rob;
        p.simid    = 16'h5A00 | 16'(rob);
        p.dst_vld  = rob[0];
        p.dst_reg  = rob[4:0];
        p.dst_data = 32'hC0DE0000 + 32'(rob);
        p.ebreak   = eb;
        p.stamp    = st;
        return p;
    endfunction

    task automatic drive(input logic rv, input t_retire_trace_pkt p, input logic rdy);
        retire_valid_rb1    = rv;
        retire_robid_rb1    = p.robid;
        retire_simid_rb1    = p.simid;
        retire_dst_vld_rb1  = p.dst_vld;
        retire_dst_reg_rb1  = p.dst_reg;
        retire_dst_data_rb1 = p.dst_data;
        retire_ebreak_rb1   = p.ebreak;
        trace_ready         = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int ncyc);
        reset = 1'b1;
        drive(1'b0, mk(6'd0, 1'b0, 32'd0), 1'b0);
        repeat (ncyc) step();
        check("rst_valid", 128'(trace_valid), 128'(0));
        check("rst_pkt",   128'(trace_pkt),   128'(0));
        check("rst_hang",  128'(hang_detected), 128'(0));
        check("rst_done",  128'(done), 128'(0));
        check("rst_rc",    128'(retire_count), 128'(0));
        check("rst_dc",    128'(drop_count), 128'(0));
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_st   = 0;
        m_last = 0;
        m_hang = 1'b0;
        m_rc   = '0;
        m_dc   = '0;
    endtask

    task automatic model_check();
        t_retire_trace_pkt e;
        e = '0;
        if (mq.size() > 0) e = mq[0];
        check("m_valid", 128'(trace_valid), 128'(mq.size() > 0));
        check("m_pkt",   128'(trace_pkt), 128'(e));
        check("m_hang",  128'(hang_detected), 128'(m_hang));
        check("m_done",  128'(done), 128'(m_st == 2));
        check("m_rc",    128'(retire_count), 128'(m_rc));
        check("m_dc",    128'(drop_count), 128'(m_dc));
    endtask

    // One cycle of the model: 0=RUN, 1=DRAIN, 2=DONE; hang fires HT cycles after the last retire/reset.
    task automatic model_step(input logic rv, input t_retire_trace_pkt p, input logic rdy);
        int   s;
        logic deq;
        logic hn;
        s   = mq.size();
        deq = (s > 0) && rdy;
        if (deq) void'(mq.pop_front());
        if (m_st == 0 && rv) begin
            if (s < DEPTH || deq) begin
                p.stamp = 32'(cyc);
                mq.push_back(p);
            end else if (m_dc != 16'hFFFF) begin
                m_dc = m_dc + 16'd1;
            end
        end
        if (rv) begin
            m_rc   = m_rc + 32'd1;
            m_last = cyc;
        end
        hn = m_hang || ((cyc + 1 - m_last) == HT);
        if (m_st == 0 && ((rv && p.ebreak) || hn)) m_st = 1;
        else if (m_st == 1 && s == 0) m_st = 2;
        m_hang = hn;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        t_retire_trace_pkt p;
        int                n;

        // Three back-to-back retires, consumer always ready.
        tbl[0] = '{1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 32'd0};
        tbl[1] = '{1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 32'd0};
        tbl[2] = '{1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 32'd0};
        tbl[3] = '{1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 32'd0};
        tbl[4] = '{1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 32'd0};
        tbl[5] = '{1'b1, 6'd1, 1'b0, 6'd0, 32'd0, 32'd0};
        tbl[6] = '{1'b1, 6'd2, 1'b1, 6'd1, 32'd5, 32'd1};
        tbl[7] = '{1'b1, 6'd3, 1'b1, 6'd2, 32'd6, 32'd2};
        tbl[8] = '{1'b0, 6'd0, 1'b1, 6'd3, 32'd7, 32'd3};
        tbl[9] = '{1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 32'd3};

        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            check("tbl_valid", 128'(trace_valid), 128'(tbl[i].ev));
            if (tbl[i].ev) begin
                check("tbl_pkt", 128'(trace_pkt), 128'(mk(tbl[i].erob, 1'b0, tbl[i].estamp)));
            end
            check("tbl_rc", 128'(retire_count), 128'(tbl[i].erc));
            $display("vec %0d cyc %0d rv=%0d valid=%0d robid=%0d stamp=%0d rc=%0d",
                     i, cyc, tbl[i].rv, trace_valid, trace_pkt.robid, trace_pkt.stamp, retire_count);
            drive(tbl[i].rv, mk(tbl[i].rob, 1'b0, 32'd0), 1'b1);
            step();
        end

        // Fill past capacity, then a simultaneous retire+dequeue, then drain in order.
        do_reset(2);
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, mk(6'(i), 1'b0, 32'd0), 1'b0);
            step();
        end
        check("full_valid", 128'(trace_valid), 128'(1));
        check("full_head",  128'(trace_pkt), 128'(mk(6'd0, 1'b0, 32'd0)));
        check("full_dc",    128'(drop_count), 128'(2));
        check("full_rc",    128'(retire_count), 128'(18));
        drive(1'b1, mk(6'd40, 1'b0, 32'd0), 1'b1);
        step();
        check("swap_dc", 128'(drop_count), 128'(2));
        check("swap_rc", 128'(retire_count), 128'(19));
        for (int j = 0; j < 16; j++) begin
            logic [5:0]  er;
            logic [31:0] es;
            er = (j < 15) ? 6'(j + 1) : 6'd40;
            es = (j < 15) ? 32'(j + 1) : 32'd18;
            check("drain_valid", 128'(trace_valid), 128'(1));
            check("drain_pkt", 128'(trace_pkt), 128'(mk(er, 1'b0, es)));
            $display("drain %0d cyc %0d robid=%0d stamp=%0d", j, cyc, trace_pkt.robid, trace_pkt.stamp);
            drive(1'b0, mk(6'd0, 1'b0, 32'd0), 1'b1);
            step();
        end
        check("drained_valid", 128'(trace_valid), 128'(0));
        check("drained_done",  128'(done), 128'(0));

        // Hang: single retire at cycle 10, hang must rise at cycle 50.
        do_reset(2);
        while (cyc < 50) begin
            if (cyc == 11) check("hang_pkt", 128'(trace_pkt), 128'(mk(6'd7, 1'b0, 32'd10)));
            if (cyc == 49) check("hang_early", 128'(hang_detected), 128'(0));
            drive(cyc == 10, mk(6'd7, 1'b0, 32'd0), 1'b1);
            step();
        end
        check("hang_rise", 128'(hang_detected), 128'(1));
        check("hang_done0", 128'(done), 128'(0));
        $display("hang cyc %0d hang=%0d rc=%0d", cyc, hang_detected, retire_count);
        n = 0;
        while (!done && n < 8) begin
            step();
            n++;
        end
        check("hang_done", 128'(done), 128'(1));
        drive(1'b1, mk(6'd8, 1'b0, 32'd0), 1'b1);
        step();
        drive(1'b0, mk(6'd0, 1'b0, 32'd0), 1'b1);
        step();
        check("hang_sticky", 128'(hang_detected), 128'(1));
        check("done_sticky", 128'(done), 128'(1));
        check("done_noenq", 128'(trace_valid), 128'(0));
        check("done_rc", 128'(retire_count), 128'(2));

        // EBREAK behind two packets, three later retires ignored by the buffer.
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, mk(6'(i + 1), i == 2, 32'd0), 1'b0);
            step();
        end
        check("eb_rc", 128'(retire_count), 128'(6));
        check("eb_dc", 128'(drop_count), 128'(0));
        for (int j = 0; j < 3; j++) begin
            check("eb_valid", 128'(trace_valid), 128'(1));
            check("eb_pkt", 128'(trace_pkt), 128'(mk(6'(j + 1), j == 2, 32'(j))));
            $display("ebreak drain %0d cyc %0d robid=%0d ebreak=%0d", j, cyc, trace_pkt.robid, trace_pkt.ebreak);
            drive(1'b0, mk(6'd0, 1'b0, 32'd0), 1'b1);
            step();
        end
        check("eb_empty", 128'(trace_valid), 128'(0));
        n = 0;
        while (!done && n < 8) begin
            step();
            n++;
        end
        check("eb_done", 128'(done), 128'(1));

        // Reset while draining with five packets queued.
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, mk(6'(i + 1), i == 4, 32'd0), 1'b0);
            step();
        end
        check("rd_valid", 128'(trace_valid), 128'(1));
        check("rd_done", 128'(done), 128'(0));
        do_reset(1);
        drive(1'b1, mk(6'd9, 1'b0, 32'd0), 1'b1);
        step();
        check("rd_run_pkt", 128'(trace_pkt), 128'(mk(6'd9, 1'b0, 32'd0)));
        check("rd_run_rc", 128'(retire_count), 128'(1));
        drive(1'b0, mk(6'd0, 1'b0, 32'd0), 1'b1);
        step();
        check("rd_discard", 128'(trace_valid), 128'(0));

        // Randomized traffic against the model, varying consumer back-pressure.
        for (int ep = 0; ep < 4; ep++) begin
            int rdy_pct;
            rdy_pct = (ep == 0) ? 15 : (ep == 1) ? 50 : (ep == 2) ? 90 : 35;
            do_reset(2);
            model_reset();
            for (int k = 0; k < 300; k++) begin
                logic rv;
                logic rdy;
                model_check();
                rv           = ($urandom_range(0, 99) < 60);
                rdy          = ($urandom_range(0, 99) < rdy_pct);
                p.robid      = 6'($urandom);
                p.simid      = 16'($urandom);
                p.dst_vld    = 1'($urandom);
                p.dst_reg    = 5'($urandom);
                p.dst_data   = $urandom;
                p.ebreak     = ($urandom_range(0, 199) == 0) || (k == 250);
                p.stamp      = '0;
                drive(rv, p, rdy);
                model_step(rv, p, rdy);
                step();
            end
            $display("episode %0d ready%%=%0d rc=%0d dc=%0d done=%0d", ep, rdy_pct, retire_count, drop_count, done);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
